// File: rtl/dphy_clk_lane_ctrl_if.sv
// Signal bundle between the D-PHY clock-lane controller and its environment.
//   lock       PLL lock, asynchronous to the controller clock
//   en         request continuous HS clock
//   clr        one-cycle pulse clearing lock_lost and retry_cnt
//   pll_resetb PLL reset, active low
//   dphy_rstn  data-lane/serializer reset, active low
//   clk_lp     clock-lane LP state {P,N}
//   clk_hs_en  selects PLL HS clock onto the lane
//   ready      HS clock running, data lanes may start
//   lock_lost  sticky: lock lost after being acquired
//   retry_cnt  saturating count of PLL reset attempts after the first
// The master modport is the environment (PLL wrapper + requester); slave is the controller.
interface dphy_clk_lane_ctrl_if;
    logic       lock;
    logic       en;
    logic       clr;
    logic       pll_resetb;
    logic       dphy_rstn;
    logic [1:0] clk_lp;
    logic       clk_hs_en;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    modport master (
        output lock, en, clr,
        input  pll_resetb, dphy_rstn, clk_lp, clk_hs_en, ready, lock_lost, retry_cnt
    );

    modport slave (
        input  lock, en, clr,
        output pll_resetb, dphy_rstn, clk_lp, clk_hs_en, ready, lock_lost, retry_cnt
    );
endinterface

// File: rtl/dphy_clk_lane_ctrl.sv
// D-PHY PLL supervisor and clock-lane sequencer. Holds the PLL in reset, waits for a stable
// lock (retrying on timeout), then walks the clock lane LP-11 -> LP-01 -> LP-00 -> HS-zero ->
// continuous HS on request, and back through trail/exit when the request drops. Lock loss in
// any post-lock state restarts from PLL reset.
// Ports:
//   clk    free-running reference clock (27 MHz)
//   rst_n  asynchronous active-low reset
//   bus    controller side of dphy_clk_lane_ctrl_if (see interface header)
module dphy_clk_lane_ctrl #(
    parameter int unsigned PLL_RST_CYC      = 8,
    parameter int unsigned LOCK_STABLE_CYC  = 256,
    parameter int unsigned LOCK_TIMEOUT_CYC = 4096,
    parameter int unsigned T_INIT_CYC       = 2700,
    parameter int unsigned T_LPX_CYC        = 2,
    parameter int unsigned T_PREP_CYC       = 2,
    parameter int unsigned T_ZERO_CYC       = 8,
    parameter int unsigned T_TRAIL_CYC      = 3,
    parameter int unsigned T_EXIT_CYC       = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    dphy_clk_lane_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        StPllRst, StWaitLock, StInit, StIdle, StLp01, StLp00, StHsZero, StHsRun, StTrail, StExit
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] stab_q, stab_d;
    logic        lock_meta_q, lock_s_q, lock_low_q;
    logic [3:0]  retry_q, retry_d;
    logic        lost_q, lost_d;
    logic        pll_resetb_q, pll_resetb_d;
    logic        dphy_rstn_q, dphy_rstn_d;
    logic [1:0]  clk_lp_q, clk_lp_d;
    logic        hs_en_q, hs_en_d;
    logic        ready_q, ready_d;
    logic        timer_zero, lost_now, inc_retry;

    // Each timed state loads N-1 on entry so it lasts exactly N cycles.
    function automatic logic [15:0] load_val(state_e s);
        unique case (s)
            StPllRst:   load_val = 16'(PLL_RST_CYC - 1);
            StWaitLock: load_val = 16'(LOCK_TIMEOUT_CYC - 1);
            StInit:     load_val = 16'(T_INIT_CYC - 1);
            StLp01:     load_val = 16'(T_LPX_CYC - 1);
            StLp00:     load_val = 16'(T_PREP_CYC - 1);
            StHsZero:   load_val = 16'(T_ZERO_CYC - 1);
            StTrail:    load_val = 16'(T_TRAIL_CYC - 1);
            StExit:     load_val = 16'(T_EXIT_CYC - 1);
            default:    load_val = 16'd0;
        endcase
    endfunction

    assign timer_zero = (timer_q == 16'd0);
    // lock_low_q holds the previous lock_s, so two consecutive low cycles are required.
    assign lost_now   = !(state_q inside {StPllRst, StWaitLock}) && !lock_s_q && lock_low_q;

    always_comb begin
        state_d   = state_q;
        stab_d    = 16'd0;
        inc_retry = 1'b0;
        if (lost_now) begin
            state_d   = StPllRst;
            inc_retry = 1'b1;
        end else begin
            unique case (state_q)
                StPllRst: if (timer_zero) state_d = StWaitLock;
                StWaitLock: begin
                    if (lock_s_q) stab_d = stab_q + 16'd1;
                    if (lock_s_q && stab_q == 16'(LOCK_STABLE_CYC - 1)) begin
                        state_d = StInit;
                    end else if (timer_zero) begin
                        state_d   = StPllRst;
                        inc_retry = 1'b1;
                    end
                end
                StInit:   if (timer_zero) state_d = StIdle;
                StIdle:   if (bus.en) state_d = StLp01;
                StLp01:   if (timer_zero) state_d = StLp00;
                StLp00:   if (timer_zero) state_d = StHsZero;
                StHsZero: if (timer_zero) state_d = StHsRun;
                StHsRun:  if (!bus.en) state_d = StTrail;
                StTrail:  if (timer_zero) state_d = StExit;
                StExit:   if (timer_zero) state_d = StIdle;
                default:  state_d = StPllRst;
            endcase
        end
        if (state_d != StWaitLock) stab_d = 16'd0;

        if (state_d != state_q) timer_d = load_val(state_d);
        else                    timer_d = timer_zero ? 16'd0 : timer_q - 16'd1;

        // A set/increment wins over a coincident clear.
        if (inc_retry)    retry_d = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
        else if (bus.clr) retry_d = 4'd0;
        else              retry_d = retry_q;
        if (lost_now)     lost_d = 1'b1;
        else if (bus.clr) lost_d = 1'b0;
        else              lost_d = lost_q;
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        pll_resetb_d = (state_d != StPllRst);
        dphy_rstn_d  = !(state_d inside {StPllRst, StWaitLock});
        hs_en_d      = (state_d inside {StHsZero, StHsRun, StTrail});
        ready_d      = (state_d == StHsRun);
        if (state_d == StLp01)                                     clk_lp_d = 2'b01;
        else if (state_d inside {StLp00, StHsZero, StHsRun, StTrail}) clk_lp_d = 2'b00;
        else                                                       clk_lp_d = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StPllRst;
            timer_q      <= 16'(PLL_RST_CYC - 1);
            stab_q       <= 16'd0;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            lock_low_q   <= 1'b1;
            retry_q      <= 4'd0;
            lost_q       <= 1'b0;
            pll_resetb_q <= 1'b0;
            dphy_rstn_q  <= 1'b0;
            clk_lp_q     <= 2'b11;
            hs_en_q      <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            stab_q       <= stab_d;
            lock_meta_q  <= bus.lock;
            lock_s_q     <= lock_meta_q;
            lock_low_q   <= !lock_s_q;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            pll_resetb_q <= pll_resetb_d;
            dphy_rstn_q  <= dphy_rstn_d;
            clk_lp_q     <= clk_lp_d;
            hs_en_q      <= hs_en_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.pll_resetb = pll_resetb_q;
    assign bus.dphy_rstn  = dphy_rstn_q;
    assign bus.clk_lp     = clk_lp_q;
    assign bus.clk_hs_en  = hs_en_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lost_q;
    assign bus.retry_cnt  = retry_q;

endmodule

// File: tb/tb_dphy_clk_lane_ctrl.sv
// Self-checking bench for dphy_clk_lane_ctrl: directed sequence with randomized EN timing and
// lock glitches, checked every cycle against a phase/elapsed-time reference model.
module tb_dphy_clk_lane_ctrl;

    localparam int PLL_RST_CYC      = 8;
    localparam int LOCK_STABLE_CYC  = 256;
    localparam int LOCK_TIMEOUT_CYC = 4096;
    localparam int T_INIT_CYC       = 2700;
    localparam int T_LPX_CYC        = 2;
    localparam int T_PREP_CYC       = 2;
    localparam int T_ZERO_CYC       = 8;
    localparam int T_TRAIL_CYC      = 3;
    localparam int T_EXIT_CYC       = 3;

    localparam int PH_RST = 0, PH_WAIT = 1, PH_INIT = 2, PH_IDLE = 3, PH_LP01 = 4, PH_LP00 = 5;
    localparam int PH_HSZ = 6, PH_HSRUN = 7, PH_TRAIL = 8, PH_EXIT = 9;

    // {pll_resetb, dphy_rstn, clk_lp, clk_hs_en, ready, lock_lost, retry_cnt}
    localparam logic [10:0] RST_VEC = {1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0};

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec, n_err;

    dphy_clk_lane_ctrl_if bus ();

    dphy_clk_lane_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase, cycles spent in it, run of stable lock samples, raw lock history.
    int m_ph, m_age, m_run, m_retry;
    bit m_lost;
    bit hist[$];

    function automatic int dur(int ph);
        case (ph)
            PH_RST:   return PLL_RST_CYC;
            PH_INIT:  return T_INIT_CYC;
            PH_LP01:  return T_LPX_CYC;
            PH_LP00:  return T_PREP_CYC;
            PH_HSZ:   return T_ZERO_CYC;
            PH_TRAIL: return T_TRAIL_CYC;
            PH_EXIT:  return T_EXIT_CYC;
            default:  return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = PH_RST; m_age = 0; m_run = 0; m_retry = 0; m_lost = 1'b0;
        hist.delete();
        repeat (4) hist.push_back(1'b0);
    endtask

    // Evaluated at each rising edge with the inputs the DUT sees on that edge.
    task automatic model_step();
        bit ls, lsp, inc, lost_now;
        int nxt;
        hist.push_back(bus.lock);
        void'(hist.pop_front());
        lsp = hist[0];  // raw sample three edges ago
        ls  = hist[1];  // raw sample two edges ago = synchronized lock seen now
        nxt = m_ph;
        inc = 1'b0;
        lost_now = (m_ph >= PH_INIT) && !ls && !lsp;
        if (lost_now) begin
            nxt = PH_RST; inc = 1'b1;
        end else if (m_ph == PH_WAIT) begin
            m_run = ls ? m_run + 1 : 0;
            if (m_run == LOCK_STABLE_CYC) nxt = PH_INIT;
            else if (m_age + 1 == LOCK_TIMEOUT_CYC) begin nxt = PH_RST; inc = 1'b1; end
        end else if (m_ph == PH_IDLE) begin
            if (bus.en) nxt = PH_LP01;
        end else if (m_ph == PH_HSRUN) begin
            if (!bus.en) nxt = PH_TRAIL;
        end else if (m_age + 1 >= dur(m_ph)) begin
            nxt = (m_ph == PH_EXIT) ? PH_IDLE : m_ph + 1;
        end
        if (nxt != PH_WAIT) m_run = 0;
        m_age = (nxt == m_ph) ? m_age + 1 : 0;
        if (inc) m_retry = (m_retry < 15) ? m_retry + 1 : 15;
        else if (bus.clr) m_retry = 0;
        if (lost_now) m_lost = 1'b1;
        else if (bus.clr) m_lost = 1'b0;
        m_ph = nxt;
    endtask

    function automatic logic [10:0] exp_vec();
        logic [1:0] lp;
        if (m_ph == PH_LP01) lp = 2'b01;
        else if (m_ph inside {PH_LP00, PH_HSZ, PH_HSRUN, PH_TRAIL}) lp = 2'b00;
        else lp = 2'b11;
        return {m_ph != PH_RST, !(m_ph inside {PH_RST, PH_WAIT}), lp,
                m_ph inside {PH_HSZ, PH_HSRUN, PH_TRAIL}, m_ph == PH_HSRUN, m_lost, 4'(m_retry)};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {bus.pll_resetb, bus.dphy_rstn, bus.clk_lp, bus.clk_hs_en, bus.ready,
                bus.lock_lost, bus.retry_cnt};
    endfunction

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic check_vec(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
        if (n_err >= 20) finish_run();
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance model on the edge, compare every output just after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_vec("cycle", obs_vec(), exp_vec());
    endtask

    task automatic wait_phase(input int ph, input int max);
        int c;
        c = 0;
        while (m_ph != ph && c < max) begin tick(); c++; end
        if (m_ph != ph) begin
            n_err++;
            $error("FAIL wait_phase: phase %0d required %0d after %0d cycles", m_ph, ph, max);
        end
    endtask

    initial begin
        int cnt, len, g;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; bus.lock = 1'b0; bus.en = 1'b0; bus.clr = 1'b0;
        model_reset();
        #23;
        check_vec("reset_values", obs_vec(), RST_VEC);
        #10 rst_n = 1'b1;

        // Power-up: PLL reset width, lock acquisition, INIT length, EN held high into IDLE.
        cnt = 0;
        do begin tick(); cnt++; end while (bus.pll_resetb !== 1'b1 && cnt < 50);
        check_int("pll_rst_width", cnt, PLL_RST_CYC);
        repeat (20) tick();
        bus.lock = 1'b1;
        cnt = 0;
        do begin tick(); cnt++; end while (bus.dphy_rstn !== 1'b1 && cnt < 400);
        check_int("lock_to_init", cnt, 2 + LOCK_STABLE_CYC);
        bus.en = 1'b1;
        cnt = 0;
        do begin tick(); cnt++; end while (bus.clk_lp !== 2'b01 && cnt < 3000);
        check_int("init_to_lp01", cnt, T_INIT_CYC + 1);
        check_int("retry_powerup", int'(bus.retry_cnt), 0);
        cnt = 0;
        do begin tick(); cnt++; end while (bus.clk_hs_en !== 1'b1 && cnt < 20);
        check_int("lp01_lp00_len", cnt, T_LPX_CYC + T_PREP_CYC);
        cnt = 0;
        do begin tick(); cnt++; end while (bus.ready !== 1'b1 && cnt < 20);
        check_int("hs_zero_len", cnt, T_ZERO_CYC);
        repeat (5) tick();
        bus.en = 1'b0;
        cnt = 0;
        do begin tick(); cnt++; end while (bus.ready !== 1'b0 && cnt < 20);
        check_int("ready_drop", cnt, 1);
        cnt = 0;
        do begin tick(); cnt++; end while (bus.clk_hs_en !== 1'b0 && cnt < 20);
        check_int("trail_len", cnt, T_TRAIL_CYC);
        wait_phase(PH_IDLE, 20);

        // Randomized EN bursts (including 1-cycle pulses) with single-cycle lock glitches.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            len = $urandom_range(1, 24);
            g   = $urandom_range(0, len + 10);
            bus.en = 1'b1;
            for (int j = 0; j < len + 12; j++) begin
                if (j == len) bus.en = 1'b0;
                bus.lock = (j != g);
                tick();
            end
            bus.en = 1'b0; bus.lock = 1'b1;
            wait_phase(PH_IDLE, 60);
        end

        // Lock loss in HS_RUN after a tolerated glitch.
        bus.en = 1'b1;
        wait_phase(PH_HSRUN, 50);
        bus.lock = 1'b0; tick(); bus.lock = 1'b1;
        repeat (4) tick();
        check_int("glitch_ready", int'(bus.ready), 1);
        bus.lock = 1'b0;
        cnt = 0;
        do begin
            tick(); cnt++;
            if (cnt == 3) bus.lock = 1'b1;
        end while (bus.lock_lost !== 1'b1 && cnt < 10);
        check_int("loss_latency", cnt, 4);
        check_int("loss_hs_en", int'(bus.clk_hs_en), 0);
        check_int("loss_lp", int'(bus.clk_lp), 3);
        check_int("loss_rstn", int'(bus.dphy_rstn), 0);
        check_int("loss_retry", int'(bus.retry_cnt), 1);
        bus.en = 1'b0;
        cnt = 0;
        do begin tick(); cnt++; end while (bus.pll_resetb !== 1'b1 && cnt < 50);
        check_int("loss_pll_rst", cnt, PLL_RST_CYC);
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        check_int("clr_lost", int'(bus.lock_lost), 0);
        check_int("clr_retry", int'(bus.retry_cnt), 0);
        wait_phase(PH_IDLE, 3100);

        // Asynchronous reset mid HS_ZERO.
        bus.en = 1'b1;
        wait_phase(PH_HSZ, 20);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 check_vec("async_reset", obs_vec(), RST_VEC);
        model_reset();
        bus.en = 1'b0; bus.lock = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Lock never arrives: retries accumulate and saturate, then CLR.
        for (int k = 1; k <= 16; k++) begin
            repeat (PLL_RST_CYC + LOCK_TIMEOUT_CYC) tick();
            check_int("retry_step", int'(bus.retry_cnt), (k < 15) ? k : 15);
        end
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        check_int("retry_clr", int'(bus.retry_cnt), 0);
        repeat (5) tick();

        finish_run();
    end

endmodule
